// File: rtl/i2s_tx_stereo_if.sv
// rtl/i2s_tx_stereo_if.sv - sample-pair valid/ready handshake into i2s_tx_stereo
interface i2s_tx_stereo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_left;
    logic [DATA_WIDTH-1:0] s_right;

    modport master (output s_valid, s_left, s_right, input s_ready);
    modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_stereo.sv
// rtl/i2s_tx_stereo.sv - stereo I2S transmitter with sample-pair FIFO
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing instead of I2S.
module i2s_tx_stereo #(
    parameter int CLK_FREQ    = 44000000,
    parameter int SAMPLE_RATE = 34375,
    parameter int DATA_WIDTH  = 16,
    parameter int SLOT_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    i2s_tx_stereo_if.slave                s,
    output logic                          b_clk,
    output logic                          lr_clk,
    output logic                          i2s_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BCLK_DIV = CLK_FREQ / (2 * SAMPLE_RATE * 2 * SLOT_WIDTH);
    localparam int FW  = 2 * SLOT_WIDTH;
    localparam int BW  = $clog2(FW);
    localparam int CW  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PAD = SLOT_WIDTH - DATA_WIDTH;

    localparam logic [BW-1:0] B_LAST   = BW'(FW - 1);
    localparam logic [BW-1:0] B_SLOT   = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] B_LR_LO  = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] B_LR_HI  = BW'(FW - 2);
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

    if (BCLK_DIV < 1) begin : g_bad_div
        $error("i2s_tx_stereo: BCLK_DIV must be at least 1");
    end
    if (SLOT_WIDTH < DATA_WIDTH) begin : g_bad_slot
        $error("i2s_tx_stereo: SLOT_WIDTH must be >= DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_d;

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;

    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_idx;
    logic                  primed;
    logic [FW-1:0]         frame_sr, next_frame;
    logic [SLOT_WIDTH-1:0] slot_l, slot_r;
    logic                  div_last, fall_tick, load_frame;

    function automatic logic lr_at(input logic [BW-1:0] b);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        return b < B_SLOT;
`else
        return (b >= B_LR_LO) && (b <= B_LR_HI);
`endif
    endfunction

    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign s.s_ready = ~full;
    assign push      = s.s_valid && !full;
    assign pop       = load_frame && !empty;

    // An empty FIFO at load yields a silent frame; same-cycle pushes never bypass.
    assign slot_l     = SLOT_WIDTH'(mem_l[rd_ptr]) << PAD;
    assign slot_r     = SLOT_WIDTH'(mem_r[rd_ptr]) << PAD;
    assign next_frame = empty ? '0 : {slot_l, slot_r};

    assign div_last  = (div_cnt == DIV_LAST);
    assign fall_tick = (state == SHIFT) && b_clk && div_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        load_frame = 1'b0;
        case (state)
            IDLE:  if (en) state_d = LOAD;
            LOAD: begin
                load_frame = 1'b1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                // Last bit has been on the wire a full bit clock: chain or stop.
                if (fall_tick && primed && bit_idx == B_LAST) begin
                    if (en) load_frame = 1'b1;
                    else    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= s.s_left;
            mem_r[wr_ptr] <= s.s_right;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            b_clk    <= 1'b0;
            lr_clk   <= 1'b1;
            i2s_out  <= 1'b0;
            underrun <= 1'b0;
            bit_idx  <= '0;
            primed   <= 1'b0;
            frame_sr <= '0;
        end else begin
            underrun <= load_frame && empty;
            if (state == SHIFT) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                if (div_last) b_clk <= ~b_clk;
            end else begin
                div_cnt <= '0;
                b_clk   <= 1'b0;
            end

            if (state == LOAD) begin
                frame_sr <= next_frame;
                bit_idx  <= '0;
                primed   <= 1'b0;
            end else if (state == IDLE) begin
                lr_clk  <= 1'b1;
                i2s_out <= 1'b0;
            end else if (fall_tick) begin
                if (state_d == IDLE) begin
                    lr_clk  <= 1'b1;
                    i2s_out <= 1'b0;
                end else if (!primed) begin
                    i2s_out  <= frame_sr[FW-1];
                    frame_sr <= frame_sr << 1;
                    lr_clk   <= lr_at('0);
                    primed   <= 1'b1;
                end else if (bit_idx == B_LAST) begin
                    i2s_out  <= next_frame[FW-1];
                    frame_sr <= next_frame << 1;
                    lr_clk   <= lr_at('0);
                    bit_idx  <= '0;
                end else begin
                    i2s_out  <= frame_sr[FW-1];
                    frame_sr <= frame_sr << 1;
                    lr_clk   <= lr_at(bit_idx + 1'b1);
                    bit_idx  <= bit_idx + 1'b1;
                end
            end
        end
    end
endmodule
